// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory for the IF stage: program streamed in via a load port, fetched with 1-cycle latency.
// Optional stored-word parity checking is enabled by defining INSTR_PARITY_EN.
module instr_fetch_mem #(
  parameter int             IW    = 16,
  parameter int             DEPTH = 32,
  parameter int             AW    = 6,
  parameter logic [IW-1:0]  NOP   = 16'h0000
) (
  input  logic                         CLOCK,
  input  logic                         in_rst,
  input  logic                         in_ld_start,
  input  logic                         in_ld_valid,
  input  logic [IW-1:0]                in_ld_data,
  input  logic                         in_ld_last,
  output logic                         out_ld_ready,
  output logic                         out_ld_done,
  output logic [$clog2(DEPTH+1)-1:0]   out_ld_count,
  input  logic [AW-1:0]                in_pc,
  input  logic                         in_req,
  input  logic                         in_stall,
  output logic [IW-1:0]                out_instrn,
  output logic                         out_valid,
  output logic                         out_fault,
  output logic                         out_parity_err
);

  localparam int CW   = $clog2(DEPTH+1);
  localparam int IDXW = $clog2(DEPTH);
`ifdef INSTR_PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ld_ptr_q, ld_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [IW-1:0]     instrn_q, instrn_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              perr_q, perr_d;

  logic [MW-1:0]     mem [DEPTH];
  logic              mem_we;
  logic [MW-1:0]     mem_wdata;
  logic [MW-1:0]     rd_word;
  logic [AW-2:0]     idx;
  logic [IDXW-1:0]   rd_idx;
  logic              is_fault;
  logic              par_bad;

  // Load FSM: IDLE -> LOAD -> RUN, with reload from RUN.
  always_comb begin
    state_d  = state_q;
    ld_ptr_d = ld_ptr_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_ld_start) begin
          state_d  = S_LOAD;
          ld_ptr_d = '0;
          count_d  = '0;
        end
      end
      S_LOAD: begin
        if (in_ld_valid) begin
          mem_we   = 1'b1;
          ld_ptr_d = ld_ptr_q + IDXW'(1);
          count_d  = count_q + CW'(1);
          if (in_ld_last || (ld_ptr_q == IDXW'(DEPTH-1))) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (in_ld_start) begin
          state_d  = S_LOAD;
          ld_ptr_d = '0;
          count_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef INSTR_PARITY_EN
  assign mem_wdata = {^in_ld_data, in_ld_data};
`else
  assign mem_wdata = in_ld_data;
`endif

  assign idx      = in_pc[AW-1:1];
  assign rd_idx   = idx[IDXW-1:0];
  assign rd_word  = mem[rd_idx];
  // Anything at or beyond the loaded count is unreachable, including stale words from an older image.
  assign is_fault = in_pc[0] | ({{CW{1'b0}}, idx} >= {{(AW-1){1'b0}}, count_q});

`ifdef INSTR_PARITY_EN
  assign par_bad = (^rd_word[IW-1:0]) != rd_word[IW];
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    instrn_d = instrn_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    perr_d   = perr_q;
    if ((state_q != S_RUN) || in_ld_start) begin
      // A starting reload wins over a fetch in the same cycle.
      valid_d = 1'b0;
      fault_d = 1'b0;
      perr_d  = 1'b0;
    end else if (!in_stall) begin
      if (in_req) begin
        valid_d = 1'b1;
        if (is_fault) begin
          instrn_d = NOP;
          fault_d  = 1'b1;
          perr_d   = 1'b0;
        end else if (par_bad) begin
          instrn_d = NOP;
          fault_d  = 1'b0;
          perr_d   = 1'b1;
        end else begin
          instrn_d = rd_word[IW-1:0];
          fault_d  = 1'b0;
          perr_d   = 1'b0;
        end
      end else begin
        valid_d = 1'b0;
        fault_d = 1'b0;
        perr_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge in_rst) begin
    if (in_rst) begin
      state_q  <= S_IDLE;
      ld_ptr_q <= '0;
      count_q  <= '0;
      instrn_q <= NOP;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_ptr_q <= ld_ptr_d;
      count_q  <= count_d;
      instrn_q <= instrn_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      perr_q   <= perr_d;
    end
  end

  // Storage is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge CLOCK) begin
    if (mem_we) begin
      mem[ld_ptr_q] <= mem_wdata;
    end
  end

  assign out_ld_ready   = (state_q == S_LOAD);
  assign out_ld_done    = (state_q == S_RUN);
  assign out_ld_count   = count_q;
  assign out_instrn     = instrn_q;
  assign out_valid      = valid_q;
  assign out_fault      = fault_q;
  assign out_parity_err = perr_q;

endmodule
